// File: rtl/branch_resolver.sv
// Branch resolution unit: evaluates MIPS branch conditions, waits for the
// delay slot to issue, then pulses redirect/link-write; keeps saturating stats.
module branch_resolver #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [5:0]           op,
    input  logic [4:0]           rt,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     pc,
    input  logic [15:0]          imm,
    input  logic                 slot_issued,
    output logic                 redirect,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 link_we,
    output logic [WIDTH-1:0]     link_data,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] taken_count
);

    typedef enum logic {
        IDLE,
        SLOT
    } state_t;

    localparam int EW = (WIDTH > 18) ? WIDTH : 18;

    state_t           state;
    logic             taken_q;
    logic             link_q;
    logic             is_br;
    logic             cond;
    logic             lnk;
    logic             neg;
    logic             zero;
    logic [EW-1:0]    off;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] link_val;

    assign neg      = a[WIDTH-1];
    assign zero     = (a == '0);
    assign off      = EW'($signed({imm, 2'b00}));
    assign target   = pc + WIDTH'(4) + off[WIDTH-1:0];
    assign link_val = pc + WIDTH'(8);
    assign br_ready = (state == IDLE);

    always_comb begin
        is_br = 1'b0;
        cond  = 1'b0;
        lnk   = 1'b0;
        case (op)
            6'b000100: begin is_br = 1'b1; cond = (a == b);     end
            6'b000101: begin is_br = 1'b1; cond = (a != b);     end
            6'b000110: begin is_br = 1'b1; cond = neg | zero;   end
            6'b000111: begin is_br = 1'b1; cond = !neg && !zero; end
            6'b000001: begin
                case (rt)
                    5'b00000: begin is_br = 1'b1; cond = neg;  end
                    5'b00001: begin is_br = 1'b1; cond = !neg; end
                    5'b10000: begin is_br = 1'b1; cond = neg;  lnk = 1'b1; end
                    5'b10001: begin is_br = 1'b1; cond = !neg; lnk = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            taken_q      <= 1'b0;
            link_q       <= 1'b0;
            redirect     <= 1'b0;
            link_we      <= 1'b0;
            redirect_pc  <= '0;
            link_data    <= '0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            // pulses last one cycle; a stall also drops them
            redirect <= 1'b0;
            link_we  <= 1'b0;
            if (!stall) begin
                case (state)
                    IDLE: begin
                        if (br_valid && !flush && is_br) begin
                            state       <= SLOT;
                            taken_q     <= cond;
                            link_q      <= lnk;
                            redirect_pc <= target;
                            link_data   <= link_val;
                            if (branch_count != {CNT_WIDTH{1'b1}})
                                branch_count <= branch_count + 1'b1;
                            if (cond && taken_count != {CNT_WIDTH{1'b1}})
                                taken_count <= taken_count + 1'b1;
                        end
                    end
                    SLOT: begin
                        if (flush) begin
                            state <= IDLE;
                        end else if (slot_issued) begin
                            state    <= IDLE;
                            redirect <= taken_q;
                            link_we  <= link_q;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected pulses are queued when the
// delay slot is issued and checked when redirect/link_we fire.
module tb_branch_resolver;

    typedef struct {
        logic        rd;
        logic        lw;
        logic [31:0] tgt;
        logic [31:0] ld;
    } pulse_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_valid = 1'b0;
    logic [5:0]  op = '0;
    logic [4:0]  rt = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] pc = '0;
    logic [15:0] imm = '0;
    logic        slot_issued = 1'b0;

    logic        br_ready, redirect, link_we;
    logic [31:0] redirect_pc, link_data;
    logic [15:0] branch_count, taken_count;
    logic        br_ready2, redirect2, link_we2;
    logic [31:0] redirect_pc2, link_data2;
    logic [1:0]  branch_count2, taken_count2;

    int     nvec = 0;
    int     nerr = 0;
    int     exp_bc = 0;
    int     exp_tc = 0;
    pulse_t sb[$];

    always #5 clk = ~clk;

    branch_resolver #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_ready(br_ready), .op(op), .rt(rt),
        .a(a), .b(b), .pc(pc), .imm(imm), .slot_issued(slot_issued),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .link_we(link_we), .link_data(link_data),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    branch_resolver #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_ready(br_ready2), .op(op), .rt(rt),
        .a(a), .b(b), .pc(pc), .imm(imm), .slot_issued(slot_issued),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .link_we(link_we2), .link_data(link_data2),
        .branch_count(branch_count2), .taken_count(taken_count2)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model(
        input  logic [5:0]  mop, input logic [4:0] mrt,
        input  logic [31:0] ma, input logic [31:0] mb,
        input  logic [31:0] mpc, input logic [15:0] mimm,
        output logic isbr, output logic tk, output logic lk,
        output logic [31:0] tgt, output logic [31:0] ld);
        int sa;
        sa   = $signed(ma);
        isbr = 1'b1;
        lk   = 1'b0;
        tk   = 1'b0;
        if (mop == 6'd4)      tk = (ma == mb);
        else if (mop == 6'd5) tk = (ma != mb);
        else if (mop == 6'd6) tk = (sa <= 0);
        else if (mop == 6'd7) tk = (sa > 0);
        else if (mop == 6'd1 && mrt == 5'd0)  tk = (sa < 0);
        else if (mop == 6'd1 && mrt == 5'd1)  tk = (sa >= 0);
        else if (mop == 6'd1 && mrt == 5'd16) begin tk = (sa < 0);  lk = 1'b1; end
        else if (mop == 6'd1 && mrt == 5'd17) begin tk = (sa >= 0); lk = 1'b1; end
        else isbr = 1'b0;
        tgt = mpc + 32'd4 + {{14{mimm[15]}}, mimm, 2'b00};
        ld  = mpc + 32'd8;
    endfunction

    always @(negedge clk) begin
        if (!reset && (redirect || link_we)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {62'd0, redirect, link_we}, 64'd0);
            end else begin
                pulse_t e;
                e = sb.pop_front();
                check("redirect", redirect, e.rd);
                check("link_we", link_we, e.lw);
                if (e.rd) check("redirect_pc", redirect_pc, e.tgt);
                if (e.lw) check("link_data", link_data, e.ld);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_bc"}, branch_count, sat(exp_bc, 65535));
        check({tag, "_tc"}, taken_count, sat(exp_tc, 65535));
        check({tag, "_bc2"}, branch_count2, sat(exp_bc, 3));
        check({tag, "_tc2"}, taken_count2, sat(exp_tc, 3));
    endtask

    // mode 0: slot issued next cycle; 1: flush with slot; 2: stall 3 cycles
    task automatic do_branch(input logic [5:0] o, input logic [4:0] r,
                             input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] vpc, input logic [15:0] vimm,
                             input int mode);
        logic isbr, tk, lk;
        logic [31:0] tgt, ld;
        pulse_t e;
        model(o, r, va, vb, vpc, vimm, isbr, tk, lk, tgt, ld);
        op = o; rt = r; a = va; b = vb; pc = vpc; imm = vimm;
        br_valid = 1'b1;
        step();
        br_valid = 1'b0;
        check("ready_after_offer", br_ready, !isbr);
        if (isbr) begin
            exp_bc++;
            if (tk) exp_tc++;
            slot_issued = 1'b1;
            if (mode == 1) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
            end else begin
                if (mode == 2) begin
                    stall = 1'b1;
                    repeat (3) begin
                        step();
                        check("stall_hold", br_ready, 1'b0);
                    end
                    stall = 1'b0;
                end
                e.rd = tk; e.lw = lk; e.tgt = tgt; e.ld = ld;
                if (tk || lk) sb.push_back(e);
                step();
            end
            slot_issued = 1'b0;
            check("ready_after_slot", br_ready, 1'b1);
        end
        check_counts("cnt");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_bc = 0;
        exp_tc = 0;
    endtask

    initial begin
        step();
        check("rst_ready", br_ready, 1'b1);
        check("rst_redirect", redirect, 1'b0);
        check("rst_link_we", link_we, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_link_data", link_data, 32'h0);
        check_counts("rst");
        reset = 1'b0;
        step();

        do_branch(6'd4, 5'd0, 32'd5, 32'd5, 32'h100, 16'h0004, 0);
        step();
        check("beq_target", redirect_pc, 32'h114);
        check("beq_taken_count", taken_count, 16'd1);

        do_branch(6'd1, 5'd17, 32'hFFFF_FFFF, 32'd0, 32'h200, 16'h0010, 0);
        step();
        check("bgezal_link_data", link_data, 32'h208);

        do_branch(6'd5, 5'd0, 32'd7, 32'd7, 32'h0, 16'hFFFF, 0);
        step();
        check("bne_wrap_target", redirect_pc, 32'h0);

        do_branch(6'd1, 5'd2, 32'd0, 32'd0, 32'h40, 16'h1, 0);
        do_branch(6'd2, 5'd0, 32'd0, 32'd0, 32'h40, 16'h1, 0);

        // acceptance blocked in IDLE by flush or stall
        op = 6'd4; a = 32'd1; b = 32'd1; br_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; stall = 1'b1;
        step();
        stall = 1'b0; br_valid = 1'b0;
        check("idle_block_ready", br_ready, 1'b1);
        check_counts("idle_block");

        do_branch(6'd7, 5'd0, 32'd1, 32'd0, 32'h300, 16'h0002, 1);
        step();
        do_branch(6'd7, 5'd0, 32'd9, 32'd0, 32'h400, 16'h0008, 2);
        do_branch(6'd6, 5'd0, 32'd0, 32'd0, 32'h500, 16'h8000, 0);
        do_branch(6'd1, 5'd16, 32'h8000_0000, 32'd0, 32'h600, 16'h7FFF, 0);

        for (int i = 0; i < 24; i++) begin
            logic [5:0] ops [8];
            logic [4:0] rts [5];
            ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd2, 6'd0};
            rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2};
            do_branch(ops[$urandom_range(0, 7)], rts[$urandom_range(0, 4)],
                      32'($signed($urandom_range(0, 6)) - 3),
                      32'($signed($urandom_range(0, 6)) - 3),
                      {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                      16'($urandom), 0);
        end

        do_reset();
        for (int i = 0; i < 5; i++)
            do_branch(6'd4, 5'd0, 32'd3, 32'd3, 32'h1000, 16'h0001, 0);
        check("sat_bc2", branch_count2, 2'd3);
        check("sat_tc2", taken_count2, 2'd3);
        check("sat_tc", taken_count, 16'd5);

        op = 6'd4; a = 32'd1; b = 32'd1; pc = 32'h2000; br_valid = 1'b1;
        step();
        br_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_slot_ready", br_ready, 1'b1);
        check("rst_slot_pc", redirect_pc, 32'h0);
        check("rst_slot_ld", link_data, 32'h0);
        check("rst_slot_bc", branch_count, 16'd0);
        check("rst_slot_tc2", taken_count2, 2'd0);
        slot_issued = 1'b1;
        step();
        reset = 1'b0;
        step();
        slot_issued = 1'b0;
        repeat (3) step();

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
